// File: rtl/lc_1252_ind_streamer.sv
// Transmit side of the 1252 odd-matrix index stream: buffers host-loaded (row,col)
// pairs, streams them as AXI-Stream beats, then returns the solver's result beat.
module lc_1252_ind_streamer #(
  parameter int MAX_IND_LEN = 100,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CW = $clog2(MAX_IND_LEN) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_push,
  input  logic [7:0]    cfg_row,
  input  logic [7:0]    cfg_col,
  input  logic          cfg_clear,
  input  logic [7:0]    cfg_m,
  input  logic [7:0]    cfg_n,
  input  logic          start,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic [7:0]    m,
  output logic [7:0]    n,
  output logic [15:0]   ind_tdata,
  output logic          ind_tvalid,
  output logic          ind_tlast,
  input  logic          ind_tready,
  input  logic [7:0]    odd_cells,
  input  logic          out_tvalid,
  output logic [7:0]    result,
  output logic          done,
  output logic          timeout,
  output logic [1:0]    fsm_state
);

  localparam int AW = (MAX_IND_LEN > 1) ? $clog2(MAX_IND_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state;
  logic [15:0]   pair_mem [MAX_IND_LEN];
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] next_ptr;
  logic [AW-1:0] rd_addr;
  logic [TW-1:0] timer;
  logic          full;
  logic          start_ok;
  logic          wr_en;

  assign full      = (count == CW'(MAX_IND_LEN));
  assign start_ok  = start && (count != '0);
  assign wr_en     = !rst && (state == IDLE) && cfg_push && !cfg_clear && !start_ok && !full;
  assign next_ptr  = rd_ptr + CW'(1);
  // In IDLE the next beat to load is entry 0; in SEND it is the one after rd_ptr.
  assign rd_addr   = (state == IDLE) ? '0 : next_ptr[AW-1:0];
  assign fsm_state = state;

  // Pair storage has no reset: count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pair_mem[count[AW-1:0]] <= {cfg_col, cfg_row};
    end
  end

  // Stream handshake: a beat transfers on every edge where ind_tvalid and
  // ind_tready are both high; once raised, ind_tvalid/tdata/tlast hold until
  // that transfer and tvalid stays high across the whole list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      ovf        <= 1'b0;
      m          <= '0;
      n          <= '0;
      ind_tvalid <= 1'b0;
      ind_tlast  <= 1'b0;
      ind_tdata  <= '0;
      result     <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      timer      <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_clear) begin
            count <= '0;
            ovf   <= 1'b0;
          end else if (start_ok) begin
            m          <= cfg_m;
            n          <= cfg_n;
            rd_ptr     <= '0;
            ind_tdata  <= pair_mem[rd_addr];
            ind_tlast  <= (count == CW'(1));
            ind_tvalid <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end else if (cfg_push) begin
            if (!full) begin
              count <= count + CW'(1);
            end else begin
              ovf <= 1'b1;
            end
          end
        end
        SEND: begin
          if (ind_tready) begin
            rd_ptr <= next_ptr;
            if (ind_tlast) begin
              ind_tvalid <= 1'b0;
              ind_tlast  <= 1'b0;
              timer      <= '0;
              state      <= WAIT_RES;
            end else begin
              ind_tdata <= pair_mem[rd_addr];
              ind_tlast <= (next_ptr == count - CW'(1));
            end
          end
        end
        WAIT_RES: begin
          // A result arriving on the final timer tick wins over the timeout.
          if (out_tvalid) begin
            result <= odd_cells;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            result  <= '0;
            done    <= 1'b1;
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc_1252_ind_streamer.sv
// Bench for lc_1252_ind_streamer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_lc_1252_ind_streamer;

  localparam int MAXL = 4;
  localparam int TMO  = 8;
  localparam int CW   = $clog2(MAXL) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          cfg_push;
  logic [7:0]    cfg_row;
  logic [7:0]    cfg_col;
  logic          cfg_clear;
  logic [7:0]    cfg_m;
  logic [7:0]    cfg_n;
  logic          start;
  logic          busy;
  logic [CW-1:0] count;
  logic          ovf;
  logic [7:0]    m;
  logic [7:0]    n;
  logic [15:0]   ind_tdata;
  logic          ind_tvalid;
  logic          ind_tlast;
  logic          ind_tready;
  logic [7:0]    odd_cells;
  logic          out_tvalid;
  logic [7:0]    result;
  logic          done;
  logic          timeout;
  logic [1:0]    fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lc_1252_ind_streamer #(.MAX_IND_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_push(cfg_push), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_clear(cfg_clear), .cfg_m(cfg_m), .cfg_n(cfg_n), .start(start), .busy(busy),
    .count(count), .ovf(ovf), .m(m), .n(n), .ind_tdata(ind_tdata),
    .ind_tvalid(ind_tvalid), .ind_tlast(ind_tlast), .ind_tready(ind_tready),
    .odd_cells(odd_cells), .out_tvalid(out_tvalid), .result(result), .done(done),
    .timeout(timeout), .fsm_state(fsm_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // md: 0 idle, 1 sending, 2 awaiting result, 3 done cycle
  bit          model_on = 1'b0;
  int          md = 0;
  int          pos = 0;
  int          tmr = 0;
  logic [15:0] lst[$];
  logic [15:0] exp_q[$];
  bit          ovf_e = 1'b0;
  bit          to_e = 1'b0;
  logic [7:0]  m_e = '0;
  logic [7:0]  n_e = '0;
  logic [7:0]  res_e = '0;

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      md = 0; pos = 0; tmr = 0;
      lst.delete(); exp_q.delete();
      ovf_e = 1'b0; to_e = 1'b0; m_e = '0; n_e = '0; res_e = '0;
    end else if (model_on) begin
      case (md)
        0: begin
          if (cfg_clear) begin
            lst.delete();
            ovf_e = 1'b0;
          end else if (start && lst.size() > 0) begin
            m_e = cfg_m; n_e = cfg_n; pos = 0; md = 1;
            exp_q = lst;
          end else if (cfg_push) begin
            if (lst.size() < MAXL) lst.push_back({cfg_col, cfg_row});
            else ovf_e = 1'b1;
          end
        end
        1: begin
          if (ind_tready) begin
            if (pos == lst.size() - 1) begin md = 2; tmr = 0; end
            else pos++;
          end
        end
        2: begin
          if (out_tvalid) begin res_e = odd_cells; to_e = 1'b0; md = 3; end
          else if (tmr == TMO - 1) begin res_e = '0; to_e = 1'b1; md = 3; end
          else tmr++;
        end
        default: md = 0;
      endcase
    end
  end

  // ---------------- compare process + stream monitors ----------------
  logic [16:0] seen_q[$];
  int          first_beat_cyc = 0;
  int          last_beat_cyc = 0;
  bit          pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b1;
  logic [15:0] pd = '0;

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", busy, (md == 1 || md == 2));
      chk("tvalid", ind_tvalid, (md == 1));
      chk("count", count, lst.size());
      chk("ovf", ovf, ovf_e);
      chk("m", m, m_e);
      chk("n", n, n_e);
      chk("result", result, res_e);
      chk("done", done, (md == 3));
      chk("timeout", timeout, (md == 3 && to_e));
      chk("state", fsm_state, md);
      if (md == 1) begin
        chk("tdata", ind_tdata, lst[pos]);
        chk("tlast", ind_tlast, (pos == lst.size() - 1));
      end
      if (pv && !pr && !prst) begin
        chk("stall_valid", ind_tvalid, 1);
        chk("stall_data", ind_tdata, pd);
        chk("stall_last", ind_tlast, pl);
      end
      if (ind_tvalid && ind_tready && !rst) begin
        if (seen_q.size() == 0) first_beat_cyc = cyc;
        seen_q.push_back({ind_tlast, ind_tdata});
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("beat_extra", 1, 0);
        end else begin
          chk("beat_data", ind_tdata, exp_q.pop_front());
          chk("beat_last", ind_tlast, (exp_q.size() == 0));
        end
      end
      if (done) chk("beats_left", exp_q.size(), 0);
    end
    pv = ind_tvalid; pr = ind_tready; pl = ind_tlast; pd = ind_tdata; prst = rst;
  end

  // ---------------- sink driver ----------------
  int         tready_mode = 0;  // 0: always ready, 1: random, 2: driven by main
  int         sink_delay = 0;   // cycles after tlast until the result beat; 0 = never
  logic [7:0] sink_val = '0;
  bit         rand_res = 1'b0;
  int         wait_cnt = 0;
  bit         saw_last;

  always @(posedge clk) begin
    saw_last = ind_tvalid && ind_tready && ind_tlast && !rst;
    #1;
    if (saw_last && sink_delay > 0) wait_cnt = sink_delay;
    out_tvalid = (wait_cnt == 1) || (rand_res && $urandom_range(0, 4) == 0);
    if (wait_cnt > 0) wait_cnt--;
    odd_cells = rand_res ? 8'($urandom_range(0, 255)) : sink_val;
    if (tready_mode == 0) ind_tready = 1'b1;
    else if (tready_mode == 1) ind_tready = ($urandom_range(0, 2) != 0);
  end

  // ---------------- driver tasks ----------------
  int         start_cyc = 0;
  int         d_cyc = 0;
  logic [7:0] d_res;
  logic       d_to;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] r, input logic [7:0] c);
    cfg_push = 1'b1; cfg_row = r; cfg_col = c;
    step();
    cfg_push = 1'b0;
  endtask

  task automatic clear_buf();
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
  endtask

  task automatic start_pulse();
    seen_q.delete();
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("done_seen", ok, 1);
    d_res = result; d_to = timeout; d_cyc = cyc;
    step();
  endtask

  // ---------------- main sequence ----------------
  logic pat[6];

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; cfg_push = 1'b0; cfg_clear = 1'b0; start = 1'b0;
    cfg_row = '0; cfg_col = '0; cfg_m = '0; cfg_n = '0;
    ind_tready = 1'b1; out_tvalid = 1'b0; odd_cells = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", ind_tvalid, 0);
    chk("rst_tdata", ind_tdata, 0);
    chk("rst_result", result, 0);
    step();

    // Two-pair transfer, sink answers 6 two cycles after tlast.
    sink_delay = 2; sink_val = 8'd6;
    push_pair(8'd0, 8'd1);
    push_pair(8'd1, 8'd1);
    cfg_m = 8'd2; cfg_n = 8'd3;
    start_pulse();
    wait_done(40);
    chk("t1_beats", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("t1_beat0", seen_q[0], 17'h00100);
      chk("t1_beat1", seen_q[1], 17'h10101);
    end
    chk("t1_result", d_res, 8'd6);
    chk("t1_timeout", d_to, 0);
    chk("t1_first_lat", first_beat_cyc - start_cyc, 1);
    chk("t1_res_lat", d_cyc - last_beat_cyc, 3);
    chk("t1_total_lat", d_cyc - start_cyc, 5);
    chk("t1_m", m, 8'd2);
    chk("t1_n", n, 8'd3);

    // Same list replayed under a stalling sink.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tready_mode = 2;
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      ind_tready = pat[i];
      step();
    end
    tready_mode = 0;
    wait_done(40);
    chk("t2_beats", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("t2_beat0", seen_q[0], 17'h00100);
      chk("t2_beat1", seen_q[1], 17'h10101);
    end

    // Overflow of a 4-entry buffer.
    clear_buf();
    for (int i = 0; i < 5; i++) push_pair(8'(i), 8'(16 + i));
    @(negedge clk);
    chk("t3_count", count, 4);
    chk("t3_ovf", ovf, 1);
    step();
    sink_delay = 3; sink_val = 8'h2a;
    start_pulse();
    wait_done(40);
    chk("t3_beats", seen_q.size(), 4);
    if (seen_q.size() == 4) chk("t3_beat3", seen_q[3], 17'h11303);
    chk("t3_result", d_res, 8'h2a);
    clear_buf();
    @(negedge clk);
    chk("t3_clr_count", count, 0);
    chk("t3_clr_ovf", ovf, 0);
    step();

    // Start with an empty buffer is ignored.
    cfg_m = 8'd9;
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_busy", busy, 0);
      chk("t4_tvalid", ind_tvalid, 0);
      step();
    end

    // Timeout, then a replay answered with zero.
    push_pair(8'd2, 8'd3);
    sink_delay = 0;
    start_pulse();
    wait_done(40);
    chk("t5_timeout", d_to, 1);
    chk("t5_result", d_res, 0);
    chk("t5_lat", d_cyc - last_beat_cyc, 9);
    sink_delay = 1; sink_val = 8'd0;
    start_pulse();
    wait_done(40);
    chk("t5r_timeout", d_to, 0);
    chk("t5r_result", d_res, 0);
    chk("t5r_lat", d_cyc - last_beat_cyc, 2);

    // Reset in the middle of a three-beat transfer.
    clear_buf();
    for (int i = 0; i < 3; i++) push_pair(8'(40 + i), 8'(50 + i));
    tready_mode = 2; ind_tready = 1'b1;
    start_pulse();
    step();
    ind_tready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_tvalid", ind_tvalid, 0);
    chk("t6_state", fsm_state, 0);
    chk("t6_count", count, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_beats", seen_q.size(), 1);
    step();
    tready_mode = 0;
    repeat (4) step();

    // Randomized traffic against the model.
    tready_mode = 1; rand_res = 1'b1; sink_delay = 0;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cfg_push  = ($urandom_range(0, 2) == 0);
      cfg_clear = ($urandom_range(0, 39) == 0);
      start     = ($urandom_range(0, 9) == 0);
      cfg_row   = 8'($urandom_range(0, 255));
      cfg_col   = 8'($urandom_range(0, 255));
      cfg_m     = 8'($urandom_range(0, 255));
      cfg_n     = 8'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0; cfg_push = 1'b0; cfg_clear = 1'b0; start = 1'b0;
    tready_mode = 0; rand_res = 1'b0;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
